// File: rtl/cpu_sequencer_if.sv
// Bus between the instruction controller and the cpu_sequencer datapath.
// The controller drives strobes and memory/accumulator data; the sequencer returns phase, opcode, pc and addr.
interface cpu_sequencer_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH   = 5
);
    logic                    resume;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   ac_value;
    logic                    halt;
    logic                    ld_ir;
    logic                    inc_pc;
    logic                    ld_pc;
    logic                    sel;
    logic [2:0]              phase;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    halted;

    modport master (
        output resume, data_in, ac_value, halt, ld_ir, inc_pc, ld_pc, sel,
        input  phase, opcode, zero, pc, addr, halted
    );

    modport slave (
        input  resume, data_in, ac_value, halt, ld_ir, inc_pc, ld_pc, sel,
        output phase, opcode, zero, pc, addr, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: 8-phase counter, instruction register and program counter,
// with a halt/resume freeze. addr and zero are combinational, everything else is registered.
module cpu_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH   = 5
) (
    input  logic              clk,
    input  logic              rst,
    cpu_sequencer_if.slave    bus
);
    localparam int unsigned PHASE_WIDTH = 3;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                  state;
    logic [PHASE_WIDTH-1:0]  phase;
    logic [DATA_WIDTH-1:0]   ir;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   operand;

    assign operand = ir[ADDR_WIDTH-1:0];

    // Strobes act only while running; halt beats resume when both arrive together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            phase <= '0;
            ir    <= '0;
            pc    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.halt) begin
                        state <= ST_HALT;
                    end else begin
                        phase <= phase + PHASE_WIDTH'(1);
                    end
                    if (bus.ld_ir) begin
                        ir <= bus.data_in;
                    end
                    if (bus.ld_pc) begin
                        pc <= operand;
                    end else if (bus.inc_pc) begin
                        pc <= pc + ADDR_WIDTH'(1);
                    end
                end
                ST_HALT: begin
                    if (bus.resume && !bus.halt) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.phase  = phase;
    assign bus.opcode = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign bus.pc     = pc;
    assign bus.halted = (state == ST_HALT);
    assign bus.addr   = bus.sel ? pc : operand;
    assign bus.zero   = (bus.ac_value == '0);
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer with hand-computed expectations.
module tb_cpu_sequencer;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 3;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

    cpu_sequencer #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.resume = 0; bus.data_in = '0; bus.ac_value = 8'h01;
        bus.halt = 0; bus.ld_ir = 0; bus.inc_pc = 0; bus.ld_pc = 0; bus.sel = 0;
        step();
        // Reset dominates active strobes.
        bus.ld_ir = 1; bus.data_in = 8'hFF; bus.inc_pc = 1; bus.halt = 1;
        step();
        bus.ld_ir = 0; bus.data_in = '0; bus.inc_pc = 0; bus.halt = 0;
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_addr_ir", 32'(bus.addr), 32'd0);
        bus.sel = 1; #1;
        check("rst_addr_pc", 32'(bus.addr), 32'd0);
        bus.sel = 0;
        rst = 1'b0;

        // Free run: 0..7,0,1 with pc idle.
        for (int i = 0; i < 10; i++) begin
            check($sformatf("run_phase%0d", i), 32'(bus.phase), 32'(i % 8));
            check($sformatf("run_pc%0d", i), 32'(bus.pc), 32'd0);
            step();
        end

        // Phase now 2: load IR with A5.
        check("ldir_phase", 32'(bus.phase), 32'd2);
        bus.data_in = 8'hA5; bus.ld_ir = 1;
        step();
        bus.ld_ir = 0;
        check("ldir_opcode", 32'(bus.opcode), 32'h5);
        check("ldir_addr", 32'(bus.addr), 32'h05);
        step(); step(); step();
        check("ldpc_phase", 32'(bus.phase), 32'd6);
        bus.ld_pc = 1;
        step();
        bus.ld_pc = 0;
        check("ldpc_pc", 32'(bus.pc), 32'h05);
        check("ldpc_phase_next", 32'(bus.phase), 32'd7);

        // pc wrap and ld_pc priority.
        bus.data_in = 8'h1F; bus.ld_ir = 1;
        step();
        bus.ld_ir = 0; bus.ld_pc = 1;
        step();
        bus.ld_pc = 0;
        check("pc_1f", 32'(bus.pc), 32'h1F);
        bus.inc_pc = 1;
        step();
        bus.inc_pc = 0;
        check("pc_wrap", 32'(bus.pc), 32'h00);
        bus.ld_pc = 1;
        step();
        bus.data_in = 8'h0A; bus.ld_ir = 1; bus.ld_pc = 0;
        step();
        bus.ld_ir = 0;
        check("pc_hold_1f", 32'(bus.pc), 32'h1F);
        bus.ld_pc = 1; bus.inc_pc = 1;
        step();
        bus.ld_pc = 0;
        check("pc_ld_wins", 32'(bus.pc), 32'h0A);
        step();
        bus.inc_pc = 0;
        check("pc_inc", 32'(bus.pc), 32'h0B);
        bus.sel = 1; #1;
        check("addr_sel_pc", 32'(bus.addr), 32'h0B);
        bus.sel = 0; #1;
        check("addr_sel_ir", 32'(bus.addr), 32'h0A);

        // zero flag is combinational.
        bus.ac_value = 8'h00; #1;
        check("zero_set", 32'(bus.zero), 32'd1);
        bus.ac_value = 8'h80; #1;
        check("zero_clr", 32'(bus.zero), 32'd0);

        // Halt at phase 4, strobes ignored while frozen.
        for (int i = 0; i < 8 && bus.phase != 3'd4; i++) step();
        check("halt_at4", 32'(bus.phase), 32'd4);
        bus.halt = 1;
        step();
        bus.halt = 0;
        check("halt_set", 32'(bus.halted), 32'd1);
        bus.data_in = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            bus.ld_ir = i[0]; bus.inc_pc = ~i[0]; bus.ld_pc = i[0];
            step();
            check($sformatf("halt_phase%0d", i), 32'(bus.phase), 32'd4);
            check($sformatf("halt_pc%0d", i), 32'(bus.pc), 32'h0B);
            check($sformatf("halt_ir%0d", i), 32'({bus.opcode, bus.addr}), 32'h0A);
            check($sformatf("halt_flag%0d", i), 32'(bus.halted), 32'd1);
        end
        bus.ld_ir = 0; bus.inc_pc = 0; bus.ld_pc = 0;
        bus.resume = 1;
        step();
        bus.resume = 0;
        check("resume_clr", 32'(bus.halted), 32'd0);
        check("resume_hold", 32'(bus.phase), 32'd4);
        step();
        check("resume_inc", 32'(bus.phase), 32'd5);
        bus.resume = 1;
        step();
        bus.resume = 0;
        check("resume_noop_flag", 32'(bus.halted), 32'd0);
        check("resume_noop_phase", 32'(bus.phase), 32'd6);

        // halt + resume together: halt wins, both from running and while halted.
        bus.halt = 1; bus.resume = 1;
        step();
        check("both_run", 32'(bus.halted), 32'd1);
        step();
        bus.halt = 0; bus.resume = 0;
        check("both_halted", 32'(bus.halted), 32'd1);
        check("both_phase", 32'(bus.phase), 32'd6);

        // Reset while halted.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_halt_phase", 32'(bus.phase), 32'd0);
        check("rst_halt_flag", 32'(bus.halted), 32'd0);
        check("rst_halt_pc", 32'(bus.pc), 32'd0);
        check("rst_halt_opcode", 32'(bus.opcode), 32'd0);
        step();
        check("rst_halt_run", 32'(bus.phase), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
